// File: rtl/multi_channel_timer.sv
// Multi-channel countdown timer with shared prescaler.
// Channels are one-shot or auto-reload, each with load/stop control.
module multi_channel_timer #(
    parameter int WIDTH          = 32,
    parameter int CHANNELS       = 4,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic                      Enable,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [CHANNELS-1:0]       Load,
    input  logic [WIDTH-1:0]          LoadValue,
    input  logic [CHANNELS-1:0]       Periodic,
    input  logic [CHANNELS-1:0]       Stop,
    output logic [CHANNELS*WIDTH-1:0] Count,
    output logic [CHANNELS-1:0]       Running,
    output logic [CHANNELS-1:0]       Done,
    output logic [CHANNELS-1:0]       Expire
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    logic [PRESCALE_WIDTH-1:0] pc;
    logic                      tick;

    assign tick = Enable && (pc == Prescale);

    // PC above a shrunk Prescale simply rolls over at full width
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc <= '0;
        end else if (!Enable || tick) begin
            pc <= '0;
        end else begin
            pc <= pc + PRESCALE_WIDTH'(1);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           st;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] rel;
        logic             mode;
        logic             done;
        logic             exp;

        always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
                st   <= S_IDLE;
                cnt  <= '0;
                rel  <= '0;
                mode <= 1'b0;
                done <= 1'b0;
                exp  <= 1'b0;
            end else begin
                exp <= 1'b0;
                if (Load[g]) begin
                    cnt  <= LoadValue;
                    rel  <= LoadValue;
                    done <= 1'b0;
                    if (LoadValue != '0) begin
                        st   <= S_RUN;
                        mode <= Periodic[g];
                    end else begin
                        st   <= S_DONE;
                        mode <= 1'b0;
                        done <= 1'b1;
                        exp  <= 1'b1;
                    end
                end else if (Stop[g]) begin
                    st   <= S_IDLE;
                    done <= 1'b0;
                end else if (st == S_RUN && tick) begin
                    if (cnt > WIDTH'(1)) begin
                        cnt <= cnt - WIDTH'(1);
                    end else if (mode) begin
                        cnt <= rel;
                        exp <= 1'b1;
                    end else begin
                        cnt  <= '0;
                        st   <= S_DONE;
                        done <= 1'b1;
                        exp  <= 1'b1;
                    end
                end
            end
        end

        assign Count[g*WIDTH +: WIDTH] = cnt;
        assign Running[g]              = (st == S_RUN);
        assign Done[g]                 = done;
        assign Expire[g]               = exp;
    end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed-vector bench for multi_channel_timer.
// Each task drives one scenario and checks inline.
module tb_multi_channel_timer;

    localparam int W  = 32;
    localparam int CH = 4;
    localparam int PW = 8;

    logic            Clock = 1'b0;
    logic            Reset_n;
    logic            Enable;
    logic [PW-1:0]   Prescale;
    logic [CH-1:0]   Load;
    logic [W-1:0]    LoadValue;
    logic [CH-1:0]   Periodic;
    logic [CH-1:0]   Stop;
    logic [CH*W-1:0] Count;
    logic [CH-1:0]   Running;
    logic [CH-1:0]   Done;
    logic [CH-1:0]   Expire;

    int checks   = 0;
    int failures = 0;

    multi_channel_timer #(
        .WIDTH(W),
        .CHANNELS(CH),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .Enable(Enable),
        .Prescale(Prescale),
        .Load(Load),
        .LoadValue(LoadValue),
        .Periodic(Periodic),
        .Stop(Stop),
        .Count(Count),
        .Running(Running),
        .Done(Done),
        .Expire(Expire)
    );

    always #5 Clock = ~Clock;

    function automatic logic [W-1:0] cnt(input int i);
        return Count[i*W +: W];
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        Enable    = 1'b0;
        Prescale  = '0;
        Load      = '0;
        LoadValue = '0;
        Periodic  = '0;
        Stop      = '0;
        #12;
        checks++;
        if (Count !== '0) begin
            failures++;
            $display("FAIL reset_count got=%0h exp=0", Count);
        end
        checks++;
        if ({Running, Done, Expire} !== '0) begin
            failures++;
            $display("FAIL reset_flags got=%0h exp=0", {Running, Done, Expire});
        end
        @(negedge Clock);
        Reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_oneshot();
        Enable    = 1'b1;
        Prescale  = '0;
        LoadValue = 5;
        Periodic  = '0;
        Load      = 4'b0001;
        step(1);
        Load = '0;
        checks++;
        if (cnt(0) !== 5 || Running[0] !== 1'b1) begin
            failures++;
            $display("FAIL os_load got=%0d run=%b exp=5 run=1", cnt(0), Running[0]);
        end
        for (int k = 4; k >= 0; k--) begin
            step(1);
            checks++;
            if (cnt(0) !== W'(k)) begin
                failures++;
                $display("FAIL os_count got=%0d exp=%0d", cnt(0), k);
            end
            checks++;
            if (Done[0] !== (k == 0) || Expire[0] !== (k == 0)) begin
                failures++;
                $display("FAIL os_flags k=%0d done=%b exp_pulse=%b", k, Done[0], Expire[0]);
            end
        end
        step(1);
        checks++;
        if (Expire[0] !== 1'b0 || Done[0] !== 1'b1 || Running[0] !== 1'b0 || cnt(0) !== 0) begin
            failures++;
            $display("FAIL os_after got exp=%b done=%b run=%b cnt=%0d exp 0 1 0 0",
                     Expire[0], Done[0], Running[0], cnt(0));
        end
    endtask

    task automatic test_periodic();
        int seq_c[6] = '{2, 1, 3, 2, 1, 3};
        logic seq_e[6] = '{0, 0, 1, 0, 0, 1};
        LoadValue = 3;
        Periodic  = 4'b0010;
        Load      = 4'b0010;
        step(1);
        Load = '0;
        checks++;
        if (cnt(1) !== 3) begin
            failures++;
            $display("FAIL per_load got=%0d exp=3", cnt(1));
        end
        for (int k = 0; k < 6; k++) begin
            step(1);
            checks++;
            if (cnt(1) !== W'(seq_c[k]) || Expire[1] !== seq_e[k] || Done[1] !== 1'b0) begin
                failures++;
                $display("FAIL per_seq k=%0d cnt=%0d exp=%b done=%b want %0d %b 0",
                         k, cnt(1), Expire[1], Done[1], seq_c[k], seq_e[k]);
            end
        end
        LoadValue = 1;
        Load      = 4'b0010;
        step(1);
        Load = '0;
        for (int k = 0; k < 2; k++) begin
            step(1);
            checks++;
            if (Expire[1] !== 1'b1 || cnt(1) !== 1 || Running[1] !== 1'b1) begin
                failures++;
                $display("FAIL per_reload1 k=%0d exp=%b cnt=%0d run=%b want 1 1 1",
                         k, Expire[1], cnt(1), Running[1]);
            end
        end
    endtask

    task automatic test_prescale();
        Enable = 1'b0;
        step(1);
        Enable    = 1'b1;
        Prescale  = 3;
        LoadValue = 2;
        Periodic  = '0;
        Load      = 4'b0100;
        step(1);
        Load = '0;
        checks++;
        if (cnt(2) !== 2) begin
            failures++;
            $display("FAIL ps_load got=%0d exp=2", cnt(2));
        end
        step(2);
        checks++;
        if (cnt(2) !== 2) begin
            failures++;
            $display("FAIL ps_hold got=%0d exp=2", cnt(2));
        end
        step(1);
        checks++;
        if (cnt(2) !== 1) begin
            failures++;
            $display("FAIL ps_tick got=%0d exp=1", cnt(2));
        end
        step(1);
        Enable = 1'b0;
        step(10);
        checks++;
        if (cnt(2) !== 1 || Running[2] !== 1'b1) begin
            failures++;
            $display("FAIL ps_frozen cnt=%0d run=%b want 1 1", cnt(2), Running[2]);
        end
        Enable = 1'b1;
        step(3);
        checks++;
        if (cnt(2) !== 1 || Done[2] !== 1'b0) begin
            failures++;
            $display("FAIL ps_restart cnt=%0d done=%b want 1 0", cnt(2), Done[2]);
        end
        step(1);
        checks++;
        if (cnt(2) !== 0 || Done[2] !== 1'b1 || Expire[2] !== 1'b1) begin
            failures++;
            $display("FAIL ps_done cnt=%0d done=%b exp=%b want 0 1 1",
                     cnt(2), Done[2], Expire[2]);
        end
    endtask

    task automatic test_stop();
        Prescale  = '0;
        LoadValue = 10;
        Periodic  = '0;
        Load      = 4'b1000;
        step(1);
        Load = '0;
        step(4);
        checks++;
        if (cnt(3) !== 6) begin
            failures++;
            $display("FAIL stop_pre got=%0d exp=6", cnt(3));
        end
        Stop = 4'b1000;
        step(2);
        checks++;
        if (cnt(3) !== 6 || Running[3] !== 1'b0) begin
            failures++;
            $display("FAIL stop_hold cnt=%0d run=%b want 6 0", cnt(3), Running[3]);
        end
        LoadValue = 4;
        Load      = 4'b1000;
        step(1);
        Load = '0;
        Stop = '0;
        checks++;
        if (cnt(3) !== 4 || Running[3] !== 1'b1) begin
            failures++;
            $display("FAIL stop_loadwins cnt=%0d run=%b want 4 1", cnt(3), Running[3]);
        end
        step(1);
        checks++;
        if (cnt(3) !== 3) begin
            failures++;
            $display("FAIL stop_resume got=%0d exp=3", cnt(3));
        end
    endtask

    task automatic test_zero_load();
        LoadValue = 0;
        Periodic  = 4'b0001;
        Load      = 4'b0001;
        step(1);
        Load     = '0;
        Periodic = '0;
        checks++;
        if (Done[0] !== 1'b1 || Expire[0] !== 1'b1 || Running[0] !== 1'b0 || cnt(0) !== 0) begin
            failures++;
            $display("FAIL zero_load done=%b exp=%b run=%b cnt=%0d want 1 1 0 0",
                     Done[0], Expire[0], Running[0], cnt(0));
        end
        step(1);
        checks++;
        if (Expire[0] !== 1'b0 || Done[0] !== 1'b1) begin
            failures++;
            $display("FAIL zero_after exp=%b done=%b want 0 1", Expire[0], Done[0]);
        end
    endtask

    task automatic test_reset_midcount();
        LoadValue = 20;
        Load      = 4'b1111;
        step(1);
        Load = '0;
        step(3);
        checks++;
        if (cnt(0) !== 17 || Running !== 4'b1111) begin
            failures++;
            $display("FAIL rst_pre cnt0=%0d run=%b want 17 1111", cnt(0), Running);
        end
        Reset_n = 1'b0;
        #2;
        checks++;
        if (Count !== '0 || {Running, Done, Expire} !== '0) begin
            failures++;
            $display("FAIL rst_async cnt=%0h flags=%0h want 0 0",
                     Count, {Running, Done, Expire});
        end
        @(negedge Clock);
        Reset_n = 1'b1;
        step(3);
        checks++;
        if (Count !== '0 || Running !== '0) begin
            failures++;
            $display("FAIL rst_noresume cnt=%0h run=%b want 0 0", Count, Running);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_prescale();
        test_stop();
        test_zero_load();
        test_reset_midcount();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
